melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Upstream stage of the tone-generation path: steps through a fixed melody table at a programmable tempo and drives the 32-bit `value` note code consumed by the clock divider that produces the audible square wave. It also drives a `note_on` gate, so each note is separated by a short silence. Start, stop and loop controls come from the board switch/button logic.

## Interface
Parameters:
- `NOTE_CYC`, 25_000_000: `system_CLK` cycles per note slot (250 ms at 100 MHz); must be greater than `GAP_CYC`.
- `GAP_CYC`, 2_500_000: trailing cycles of each slot during which `note_on`=0.
- `LEN`, 16: number of melody entries, 2..256.

Ports (clock and reset first):
- `system_CLK`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins playback from entry 0.
- `stop`  in  1  single-cycle pulse; aborts playback.
- `loop`  in  1  level; when high, wrap to entry 0 after the last entry instead of finishing.
- `value`  out  32  note code for the divider; 0 = rest.
- `note_on`  out  1  audio gate; high while the note sounds.
- `index`  out  8  current melody entry.
- `busy`  out  1  high in PLAY and GAP.
- `done`  out  1  one-cycle pulse when a non-looping melody completes.

## Operation
- Melody table: combinational ROM, `LEN` entries of 32-bit codes. Entry value 0 means rest: `note_on` stays 0 for that whole slot.
- FSM states:
  - IDLE → PLAY on `start`.
  - PLAY → GAP when `slot_cnt` = `NOTE_CYC`-`GAP_CYC`-1.
  - GAP → PLAY at slot end (`slot_cnt` = `NOTE_CYC`-1) if `index`<`LEN`-1 or `loop`=1.
  - GAP → DONE at slot end otherwise.
  - DONE → IDLE unconditionally after one cycle.
- `slot_cnt`: 32-bit counter. Clears on entering PLAY from IDLE and at each slot end; otherwise increments every cycle in PLAY/GAP.
- `index`:
  - Clears to 0 on `start`.
  - At a slot end: increments, or wraps to 0 when `index`=`LEN`-1 and `loop`=1.
- `value`:
  - Registered copy of `rom[index]` in PLAY and GAP.
  - 0 in IDLE and DONE.
- `note_on` = 1 only in PLAY with `value`≠0.
- `loop` is sampled only at the slot end of the last entry.
- `stop` in any state → IDLE next cycle: `value`=0, `note_on`=0, `busy`=0, no `done` pulse.
- `stop` and `start` in the same cycle: `stop` wins.
- `start` while busy restarts from entry 0 with `slot_cnt` cleared; it is not ignored.
- `start` in DONE: go to PLAY (restart) instead of IDLE.

## Timing
- Reset values: state IDLE, `value`=0, `note_on`=0, `index`=0, `busy`=0, `done`=0, `slot_cnt`=0.
- All outputs are registered. `start` at cycle N gives `busy`=1 and `value`=`rom[0]` at N+1.
- Each slot lasts exactly `NOTE_CYC` cycles:
  - `note_on` high for `NOTE_CYC`-`GAP_CYC` cycles.
  - Low for `GAP_CYC` cycles.
- `value` updates on the same edge that starts the next slot.
- Non-looping run: `done` asserts for one cycle exactly `LEN`×`NOTE_CYC` cycles after `busy` rises; `busy` falls on that same edge.
- `stop` at cycle N: all outputs reach their idle values at N+1.

## Structure
- Shared package `audio_pkg` holds:
  - FSM state encoding (IDLE, PLAY, GAP, DONE).
  - The note-code constants shared with the divider's code-to-divisor lookup, including `NOTE_REST`=0.
- Sub-module `melody_rom` (input `index`[7:0], output `code`[31:0]): a case statement returning `NOTE_REST` for indices ≥ `LEN`. It is kept separate so melodies can be swapped without touching the FSM.

## Test plan
Bench parameters: `NOTE_CYC`=10, `GAP_CYC`=2, `LEN`=4; ROM = {5, 0, 7, 9}.
- Reset then idle 50 cycles → `value`=0, `note_on`=0, `busy`=0, `done` never pulses.
- `start` pulse, `loop`=0 → `value` sequence 5,0,7,9, each held 10 cycles.
  - `note_on` high 8 cycles, low 2 cycles per slot, except low all 10 cycles for the rest entry.
  - `done` pulses once, 40 cycles after `busy` rises.
- `loop`=1 held for 100 cycles after `start` → `index` wraps 3→0 at cycle 40 and again at 80; no `done` pulse.
- `stop` at cycle 15 of playback → next cycle `value`=0, `note_on`=0, `busy`=0; no `done` pulse.
- `start` re-pulsed at cycle 23 (during entry 2) → next cycle `index`=0, `value`=5, and the slot restarts a full 10 cycles.
- `reset` asserted mid-GAP, together with `start` → all outputs at reset values next cycle; state IDLE.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the tone-generation path.
// - state_e: melody sequencer FSM states.
// - NOTE_*: note codes understood by the divider's code-to-divisor lookup.
//   NOTE_REST (0) means silence.
// - is_active: true while a melody is being played.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] NOTE_REST = 32'd0;
  localparam logic [31:0] NOTE_C4   = 32'd1;
  localparam logic [31:0] NOTE_D4   = 32'd3;
  localparam logic [31:0] NOTE_E4   = 32'd5;
  localparam logic [31:0] NOTE_F4   = 32'd6;
  localparam logic [31:0] NOTE_G4   = 32'd7;
  localparam logic [31:0] NOTE_A4   = 32'd9;
  localparam logic [31:0] NOTE_B4   = 32'd11;
  localparam logic [31:0] NOTE_C5   = 32'd12;

  function automatic logic is_active(state_e s);
    return (s == ST_PLAY) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody table as a combinational ROM.
// Ports:
//   index [7:0]  in   melody entry to look up
//   code  [31:0] out  note code; NOTE_REST for entries at or beyond LEN
// Swap the case body to change the tune; the sequencer is untouched.
module melody_rom
  import audio_pkg::*;
#(
  parameter int unsigned LEN = 16
) (
  input  logic [7:0]  index,
  output logic [31:0] code
);

  always_comb begin
    code = NOTE_REST;
    if (32'(index) < LEN) begin
      case (index)
        8'd0:    code = NOTE_E4;
        8'd1:    code = NOTE_REST;
        8'd2:    code = NOTE_G4;
        8'd3:    code = NOTE_A4;
        8'd4:    code = NOTE_G4;
        8'd5:    code = NOTE_E4;
        8'd6:    code = NOTE_C4;
        8'd7:    code = NOTE_D4;
        8'd8:    code = NOTE_E4;
        8'd9:    code = NOTE_E4;
        8'd10:   code = NOTE_D4;
        8'd11:   code = NOTE_REST;
        8'd12:   code = NOTE_F4;
        8'd13:   code = NOTE_A4;
        8'd14:   code = NOTE_C5;
        8'd15:   code = NOTE_B4;
        default: code = NOTE_REST;
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the melody ROM at a fixed tempo and drives the divider.
// Ports:
//   system_CLK       in   system clock
//   reset            in   synchronous active-high reset
//   start            in   pulse: (re)start playback at entry 0
//   stop             in   pulse: abort playback (wins over start)
//   loop             in   level: wrap after the last entry instead of finishing
//   value   [31:0]   out  note code for the divider (0 = rest)
//   note_on          out  audio gate
//   index   [7:0]    out  current melody entry
//   busy             out  high while playing (PLAY or GAP)
//   done             out  one-cycle pulse when a non-looping melody ends
// Each slot is NOTE_CYC cycles: PLAY for NOTE_CYC-GAP_CYC, then GAP.
module melody_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned NOTE_CYC = 25_000_000,
  parameter int unsigned GAP_CYC  = 2_500_000,
  parameter int unsigned LEN      = 16
) (
  input  logic        system_CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [31:0] value,
  output logic        note_on,
  output logic [7:0]  index,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] PLAY_END = 32'(NOTE_CYC - GAP_CYC - 1);
  localparam logic [31:0] SLOT_END = 32'(NOTE_CYC - 1);
  localparam logic [7:0]  LAST_IDX = 8'(LEN - 1);

  state_e      state_q, state_d;
  logic [31:0] slot_cnt_q, slot_cnt_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] value_q, value_d;
  logic        note_on_q, note_on_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rom_code;

  // Look up the entry that will be current next cycle so value is
  // registered on the same edge that starts the slot.
  melody_rom #(.LEN(LEN)) u_rom (
    .index (index_d),
    .code  (rom_code)
  );

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    index_d    = index_q;
    done_d     = 1'b0;

    if (stop) begin
      state_d    = ST_IDLE;
      slot_cnt_d = 32'd0;
      index_d    = 8'd0;
    end else if (start) begin
      state_d    = ST_PLAY;
      slot_cnt_d = 32'd0;
      index_d    = 8'd0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          slot_cnt_d = slot_cnt_q + 32'd1;
          if (slot_cnt_q == PLAY_END) state_d = ST_GAP;
        end
        ST_GAP: begin
          if (slot_cnt_q == SLOT_END) begin
            slot_cnt_d = 32'd0;
            if (index_q < LAST_IDX) begin
              index_d = index_q + 8'd1;
              state_d = ST_PLAY;
            end else if (loop) begin
              index_d = 8'd0;
              state_d = ST_PLAY;
            end else begin
              // Last entry stays on index; the melody is finished.
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + 32'd1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d    = is_active(state_d);
    value_d   = busy_d ? rom_code : NOTE_REST;
    note_on_d = (state_d == ST_PLAY) && (value_d != NOTE_REST);
  end

  always_ff @(posedge system_CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= 32'd0;
      index_q    <= 8'd0;
      value_q    <= NOTE_REST;
      note_on_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      index_q    <= index_d;
      value_q    <= value_d;
      note_on_q  <= note_on_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign value   = value_q;
  assign note_on = note_on_q;
  assign index   = index_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int NOTE = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 4;

  logic        clk = 1'b0;
  logic        reset, start, stop, loop;
  logic [31:0] value;
  logic        note_on;
  logic [7:0]  index;
  logic        busy, done;

  int n_pass = 0;
  int n_total = 0;

  melody_sequencer #(.NOTE_CYC(NOTE), .GAP_CYC(GAP), .LEN(LEN)) dut (
    .system_CLK (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .value      (value),
    .note_on    (note_on),
    .index      (index),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed cycles since playback began and current slot.
  int  rom_m [LEN] = '{5, 0, 7, 9};
  bit  m_play;
  int  m_el;
  int  m_slot;
  bit  m_done;
  bit  m_idx_valid;

  task automatic model_tick(input bit r, input bit s, input bit p, input bit l);
    m_done = 1'b0;
    if (r) begin
      m_play = 0; m_el = 0; m_slot = 0; m_idx_valid = 1;
    end else if (p) begin
      m_play = 0; m_idx_valid = 0;
    end else if (s) begin
      m_play = 1; m_el = 0; m_slot = 0; m_idx_valid = 1;
    end else if (m_play) begin
      m_el++;
      if (m_el % NOTE == 0) begin
        if (m_slot == LEN - 1) begin
          if (l) m_slot = 0;
          else begin
            m_play = 0; m_done = 1; m_idx_valid = 0;
          end
        end else begin
          m_slot++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock: drive inputs, advance model, compare all outputs to the model.
  task automatic step(input bit r, input bit s, input bit p, input bit l);
    logic [31:0] ev;
    bit eon;
    reset = r; start = s; stop = p; loop = l;
    @(posedge clk);
    model_tick(r, s, p, l);
    #1;
    ev  = m_play ? 32'(rom_m[m_slot]) : 32'd0;
    eon = m_play && ((m_el % NOTE) < NOTE - GAP) && (ev != 0);
    chk("value", value, ev);
    chk("note_on", {31'd0, note_on}, {31'd0, eon});
    chk("busy", {31'd0, busy}, {31'd0, m_play});
    chk("done", {31'd0, done}, {31'd0, m_done});
    if (m_idx_valid) chk("index", {24'd0, index}, 32'(m_play ? m_slot : 0));
    reset = 0; start = 0; stop = 0;
  endtask

  typedef struct {
    bit          start;
    bit          stop;
    int          n;
    logic [31:0] value;
    bit          note_on;
    bit          busy;
    bit          chk_idx;
    logic [7:0]  index;
  } vec_t;

  vec_t vt [10];

  initial begin
    int done_t, done_cnt, wraps, w1, w2;
    logic [7:0] prev_idx;

    reset = 1; start = 0; stop = 0; loop = 0;
    m_play = 0; m_el = 0; m_slot = 0; m_done = 0; m_idx_valid = 1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_value", value, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_index", {24'd0, index}, 32'd0);

    done_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(0, 0, 0, 0);
      if (done) done_cnt++;
    end
    chk("idle_no_done", done_cnt, 0);

    // Directed table: walk through slots, restart at cycle 23, stop at 15.
    vt[0] = '{1, 0, 1, 5, 1, 1, 1, 0};
    vt[1] = '{0, 0, 7, 5, 1, 1, 1, 0};
    vt[2] = '{0, 0, 1, 5, 0, 1, 1, 0};
    vt[3] = '{0, 0, 2, 0, 0, 1, 1, 1};
    vt[4] = '{0, 0, 10, 7, 1, 1, 1, 2};
    vt[5] = '{0, 0, 3, 7, 1, 1, 1, 2};
    vt[6] = '{1, 0, 1, 5, 1, 1, 1, 0};
    vt[7] = '{0, 0, 9, 5, 0, 1, 1, 0};
    vt[8] = '{0, 0, 6, 0, 0, 1, 1, 1};
    vt[9] = '{0, 1, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      step(0, vt[i].start, vt[i].stop, 0);
      for (int k = 1; k < vt[i].n; k++) step(0, 0, 0, 0);
      chk($sformatf("vec%0d_value", i), value, vt[i].value);
      chk($sformatf("vec%0d_note_on", i), {31'd0, note_on}, {31'd0, vt[i].note_on});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      if (vt[i].chk_idx) chk($sformatf("vec%0d_index", i), {24'd0, index}, {24'd0, vt[i].index});
    end

    // Non-looping run: done exactly once, 40 cycles after busy rises.
    step(0, 1, 0, 0);
    done_t = -1; done_cnt = 0;
    for (int t = 1; t <= 100; t++) begin
      step(0, 0, 0, 0);
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
    end
    chk("done_time", done_t, 40);
    chk("done_count", done_cnt, 1);

    // Looping run: wraps 3->0 at cycles 40 and 80, never done.
    step(0, 1, 0, 1);
    prev_idx = index; wraps = 0; w1 = -1; w2 = -1; done_cnt = 0;
    for (int t = 1; t <= 100; t++) begin
      step(0, 0, 0, 1);
      if (done) done_cnt++;
      if (prev_idx == 8'd3 && index == 8'd0) begin
        wraps++;
        if (w1 < 0) w1 = t; else if (w2 < 0) w2 = t;
      end
      prev_idx = index;
    end
    chk("loop_wraps", wraps, 2);
    chk("loop_wrap1", w1, 40);
    chk("loop_wrap2", w2, 80);
    chk("loop_no_done", done_cnt, 0);
    step(0, 0, 1, 0);

    // Reset together with start while in GAP.
    step(0, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 0, 0, 0);
    chk("gap_note_on", {31'd0, note_on}, 32'd0);
    chk("gap_busy", {31'd0, busy}, 32'd1);
    step(1, 1, 0, 0);
    chk("rstgap_value", value, 32'd0);
    chk("rstgap_note_on", {31'd0, note_on}, 32'd0);
    chk("rstgap_busy", {31'd0, busy}, 32'd0);
    chk("rstgap_index", {24'd0, index}, 32'd0);
    chk("rstgap_done", {31'd0, done}, 32'd0);
    step(0, 0, 0, 0);
    chk("rstgap_idle", {31'd0, busy}, 32'd0);

    // Randomized traffic checked against the model every cycle.
    loop = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, s, p, l;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 99) == 0);
      l = (($urandom_range(0, 19) == 0) ? ~loop : loop);
      step(r, s, p, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
